// File: rtl/branch_unit.sv
// branch_unit: D-stage branch resolver with a PC-indexed table of 2-bit
// saturating counters used by the F stage for taken/not-taken prediction.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   F_pc                fetch PC used for the prediction lookup
//   F_predTaken         prediction for F_pc (combinational)
//   D_valid, D_stall    D-stage instruction valid / stalled this cycle
//   D_pc                PC of the D-stage instruction (table update index)
//   D_rs, D_rt          forwarded operands
//   D_cond              0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved
//   D_predTaken         prediction carried down from F
//   isBranch            branch condition true (combinational, pure compare)
//   D_mispredict        resolved outcome differs from D_predTaken (combinational)
//   branchCount         resolved-branch count (registered, wraps)
//   mispredictCount     mispredicted-branch count (registered, wraps)
module branch_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned IDX_LSB     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      F_pc,
  output logic             F_predTaken,
  input  logic             D_valid,
  input  logic             D_stall,
  input  logic [31:0]      D_pc,
  input  logic [WIDTH-1:0] D_rs,
  input  logic [WIDTH-1:0] D_rt,
  input  logic [2:0]       D_cond,
  input  logic             D_predTaken,
  output logic             isBranch,
  output logic             D_mispredict,
  output logic [31:0]      branchCount,
  output logic [31:0]      mispredictCount
);

  localparam int unsigned IDX_W    = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
  localparam logic [1:0]  CTR_INIT = 2'b01;
  localparam logic [1:0]  CTR_MAX  = 2'b11;
  localparam logic [1:0]  CTR_MIN  = 2'b00;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] d_idx;
  logic             rs_zero;
  logic             rs_neg;
  logic             cond_valid;
  logic             resolve;
  logic             unused_pc;

  // Untagged index: PC bits above the index alias onto the same entry.
  assign f_idx = F_pc[IDX_LSB +: IDX_W];
  assign d_idx = D_pc[IDX_LSB +: IDX_W];

  // Only the index bits of the PCs matter.
  assign unused_pc = ^{F_pc, D_pc};

  // Signed compares against zero reduce to sign bit and zero detect.
  assign rs_zero = (D_rs == '0);
  assign rs_neg  = D_rs[WIDTH-1];

  // Condition evaluation; independent of valid/stall.
  always_comb begin
    isBranch   = 1'b0;
    cond_valid = 1'b1;
    case (D_cond)
      3'd1:    isBranch = (D_rs == D_rt);
      3'd2:    isBranch = (D_rs != D_rt);
      3'd3:    isBranch = rs_neg | rs_zero;
      3'd4:    isBranch = ~rs_neg & ~rs_zero;
      3'd5:    isBranch = rs_neg;
      3'd6:    isBranch = ~rs_neg;
      default: cond_valid = 1'b0;
    endcase
  end

  assign resolve      = D_valid & ~D_stall & cond_valid;
  assign D_mispredict = resolve & (isBranch != D_predTaken);

  // No read-during-write bypass: the F stage sees the pre-update counter.
  assign F_predTaken = bht[f_idx][1];

  // Counter table and statistics; reset takes priority over a resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
        bht[i] <= CTR_INIT;
      end
      branchCount     <= 32'd0;
      mispredictCount <= 32'd0;
    end else if (resolve) begin
      if (isBranch) begin
        if (bht[d_idx] != CTR_MAX) bht[d_idx] <= bht[d_idx] + 2'd1;
      end else begin
        if (bht[d_idx] != CTR_MIN) bht[d_idx] <= bht[d_idx] - 2'd1;
      end
      branchCount <= branchCount + 32'd1;
      if (D_mispredict) mispredictCount <= mispredictCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: table-driven and hand-sequenced checks of branch_unit.
// Expected statistics counts are queued when a cycle is driven and compared
// after the clock edge; prediction and compare results use fixed constants.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_pc;
  logic        F_predTaken;
  logic        D_valid;
  logic        D_stall;
  logic [31:0] D_pc;
  logic [31:0] D_rs;
  logic [31:0] D_rt;
  logic [2:0]  D_cond;
  logic        D_predTaken;
  logic        isBranch;
  logic        D_mispredict;
  logic [31:0] branchCount;
  logic [31:0] mispredictCount;

  always #5 clk = ~clk;

  branch_unit #(.WIDTH(32), .BHT_ENTRIES(64), .IDX_LSB(2)) dut (
    .clk(clk), .reset(reset),
    .F_pc(F_pc), .F_predTaken(F_predTaken),
    .D_valid(D_valid), .D_stall(D_stall), .D_pc(D_pc),
    .D_rs(D_rs), .D_rt(D_rt), .D_cond(D_cond), .D_predTaken(D_predTaken),
    .isBranch(isBranch), .D_mispredict(D_mispredict),
    .branchCount(branchCount), .mispredictCount(mispredictCount)
  );

  typedef struct {
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [2:0]  cond;
    logic        pred;
    logic        exp_isb;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[17];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_bc = 32'd0;
  logic [31:0] m_mc = 32'd0;
  logic        pre_pred;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, queue
  // the expected counts, then compare them after the rising edge.
  task automatic step(input logic rst, input logic valid, input logic stall,
                      input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [2:0] cond, input logic pred, input logic exp_isb,
                      input string name);
    logic res;
    logic emisp;
    exp_t e;
    @(negedge clk);
    reset = rst; D_valid = valid; D_stall = stall; D_pc = pc;
    D_rs = rs; D_rt = rt; D_cond = cond; D_predTaken = pred;
    #1;
    pre_pred = F_predTaken;
    res   = valid && !stall && (cond != 3'd0) && (cond != 3'd7);
    emisp = res && (exp_isb != pred);
    chk({name, " isBranch"}, 32'(isBranch), 32'(exp_isb));
    chk({name, " mispredict"}, 32'(D_mispredict), 32'(emisp));
    if (rst) begin
      m_bc = 32'd0; m_mc = 32'd0;
    end else if (res) begin
      m_bc = m_bc + 32'd1;
      if (emisp) m_mc = m_mc + 32'd1;
    end
    e.bc = m_bc; e.mc = m_mc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0; D_valid = 1'b0; D_stall = 1'b0;
    if (sb.size() == 0) begin
      chk({name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, " branchCount"}, branchCount, e.bc);
      chk({name, " mispredictCount"}, mispredictCount, e.mc);
    end
  endtask

  task automatic check_pred(input logic [31:0] pc, input logic exp, input string name);
    F_pc = pc;
    #1;
    chk({name, " F_predTaken"}, 32'(F_predTaken), 32'(exp));
  endtask

  function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [2:0] cond,
                              input logic pred, input logic exp_isb);
    vec_t v;
    v.valid = valid; v.pc = pc; v.rs = rs; v.rt = rt;
    v.cond = cond; v.pred = pred; v.exp_isb = exp_isb;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] sat_pat;
    logic [4:0] sat_exp;

    // Comparison vectors; PCs 0x3080.. map to entries away from the hand tests.
    tbl[0]  = mk(1'b1, 32'h3080, 32'h0000_0005, 32'h0000_0005, 3'd2, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 32'h3084, 32'h0000_0005, 32'h0000_0006, 3'd2, 1'b1, 1'b1);
    tbl[2]  = mk(1'b1, 32'h3088, 32'hFFFF_FFFF, 32'h0000_0000, 3'd3, 1'b1, 1'b1);
    tbl[3]  = mk(1'b1, 32'h308C, 32'hFFFF_FFFF, 32'h0000_0000, 3'd4, 1'b1, 1'b0);
    tbl[4]  = mk(1'b1, 32'h3090, 32'hFFFF_FFFF, 32'h0000_0000, 3'd5, 1'b0, 1'b1);
    tbl[5]  = mk(1'b1, 32'h3094, 32'hFFFF_FFFF, 32'h0000_0000, 3'd6, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 32'h3098, 32'h0000_0000, 32'h1234_5678, 3'd3, 1'b0, 1'b1);
    tbl[7]  = mk(1'b1, 32'h309C, 32'h0000_0000, 32'h1234_5678, 3'd6, 1'b1, 1'b1);
    tbl[8]  = mk(1'b1, 32'h30A0, 32'h0000_0000, 32'h1234_5678, 3'd5, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 32'h30A4, 32'h0000_0000, 32'h1234_5678, 3'd4, 1'b0, 1'b0);
    tbl[10] = mk(1'b1, 32'h30A8, 32'h7FFF_FFFF, 32'h0000_0000, 3'd4, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, 32'h30AC, 32'h8000_0000, 32'h0000_0000, 3'd5, 1'b1, 1'b1);
    tbl[12] = mk(1'b1, 32'h30B0, 32'h0000_0007, 32'h0000_0007, 3'd0, 1'b1, 1'b0);
    tbl[13] = mk(1'b1, 32'h30B4, 32'h0000_0007, 32'h0000_0007, 3'd7, 1'b1, 1'b0);
    tbl[14] = mk(1'b1, 32'h30B8, 32'h0000_0001, 32'h0000_0002, 3'd1, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 32'h30BC, 32'h0000_0009, 32'h0000_0009, 3'd1, 1'b0, 1'b1);
    tbl[16] = mk(1'b1, 32'h30C0, 32'h8000_0000, 32'h0000_0000, 3'd6, 1'b1, 1'b0);

    reset = 1'b1; F_pc = 32'h3000; D_valid = 1'b0; D_stall = 1'b0; D_pc = 32'h0;
    D_rs = 32'h0; D_rt = 32'h0; D_cond = 3'd0; D_predTaken = 1'b0;

    // Reset for two cycles.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, "reset0");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, "reset1");
    check_pred(32'h3000, 1'b0, "after_reset");

    // Taken beq predicted not-taken: mispredict, entry 01 -> 10.
    step(1'b0, 1'b1, 1'b0, 32'h3004, 32'h1234, 32'h1234, 3'd1, 1'b0, 1'b1, "beq_first");
    chk("beq_first branchCount abs", branchCount, 32'd1);
    chk("beq_first mispredictCount abs", mispredictCount, 32'd1);
    check_pred(32'h3004, 1'b1, "beq_first_trained");

    // Table of compare vectors.
    for (int i = 0; i < 17; i++) begin
      step(1'b0, tbl[i].valid, 1'b0, tbl[i].pc, tbl[i].rs, tbl[i].rt, tbl[i].cond,
           tbl[i].pred, tbl[i].exp_isb, $sformatf("vec%0d", i));
    end
    check_pred(32'h3084, 1'b1, "vec1_trained");
    check_pred(32'h3080, 1'b0, "vec0_trained");
    check_pred(32'h30B0, 1'b0, "none_untouched");
    check_pred(32'h30B4, 1'b0, "reserved_untouched");
    check_pred(32'h30BC, 1'b0, "invalid_untouched");

    // Saturation on 0x3010: 5 taken, 3 not-taken, 1 more not-taken, 1 taken.
    sat_pat = 5'b11111;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h3010, 32'h0, 32'h0, 3'd1, 1'b1, 1'b1, $sformatf("sat_t%0d", i));
      check_pred(32'h3010, sat_pat[i], $sformatf("sat_t%0d", i));
    end
    sat_exp = 5'b00001;  // 11->10, 10->01, 01->00, 00->00, then taken 00->01
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h3010, 32'h0, 32'h1, 3'd1, 1'b0, 1'b0, $sformatf("sat_n%0d", i));
      check_pred(32'h3010, sat_exp[i], $sformatf("sat_n%0d", i));
    end
    step(1'b0, 1'b1, 1'b0, 32'h3010, 32'h0, 32'h0, 3'd1, 1'b0, 1'b1, "sat_floor_up");
    check_pred(32'h3010, sat_exp[4], "sat_floor_up");

    // Stalled taken bne: no update for three cycles, exactly one on release.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'h3030, 32'h5, 32'h6, 3'd2, 1'b0, 1'b1, $sformatf("stall%0d", i));
      check_pred(32'h3030, 1'b0, $sformatf("stall%0d", i));
    end
    step(1'b0, 1'b1, 1'b0, 32'h3030, 32'h5, 32'h6, 3'd2, 1'b0, 1'b1, "stall_release");
    check_pred(32'h3030, 1'b1, "stall_release");

    // Read-during-write on 0x3020: old value this cycle, new value next.
    F_pc = 32'h3020;
    step(1'b0, 1'b1, 1'b0, 32'h3020, 32'h9, 32'h9, 3'd1, 1'b0, 1'b1, "rdw");
    chk("rdw same_cycle F_predTaken", 32'(pre_pred), 32'd0);
    check_pred(32'h3020, 1'b1, "rdw_next");

    // Aliasing: 0x3000 and 0x3100 share index 0.
    step(1'b0, 1'b1, 1'b0, 32'h3000, 32'h1, 32'h1, 3'd1, 1'b0, 1'b1, "alias0");
    step(1'b0, 1'b1, 1'b0, 32'h3000, 32'h1, 32'h1, 3'd1, 1'b1, 1'b1, "alias1");
    check_pred(32'h3100, 1'b1, "alias");

    // Reset on the same edge as a resolve: reset wins.
    step(1'b1, 1'b1, 1'b0, 32'h3020, 32'h1, 32'h1, 3'd1, 1'b0, 1'b1, "reset_resolve");
    chk("reset_resolve branchCount abs", branchCount, 32'd0);
    check_pred(32'h3020, 1'b0, "reset_resolve");
    check_pred(32'h3100, 1'b0, "reset_alias");
    step(1'b0, 1'b1, 1'b0, 32'h3020, 32'h1, 32'h1, 3'd1, 1'b0, 1'b1, "post_reset_train");
    check_pred(32'h3020, 1'b1, "post_reset_train");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
